jtcps1_bank_nslots: RTL
=======================

// Module: jtcps1_bank_nslots
// PURPOSE
// Generalised SDRAM bank front-end. It arbitrates SLOTS read clients onto one SDRAM bank port.
// Each slot has its own offset, a one-line 32-bit cache and sub-word repacking. Slot 0 can
// optionally write (WR_EN). Successor to the fixed 2-slot ROM/RAM bank wrappers in the CPS1/1.5/2 SDRAM glue.
// PARAMETERS
// SLOTS    2        number of client slots, 1..4
// AW       22       slot address width (units of DW bits), common to all slots
// DW       16       slot data width: 8, 16 or 32 (all slots)
// OFFSETS  0        SLOTS*22-bit packed per-slot SDRAM word offset; slot i at [22*i+:22]
// RR       1        1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
// WR_EN    0        1 = slot 0 may write (16-bit, byte mask)
// PORTS
// clk          in   1         SDRAM clock (96 MHz); sole clock
// rst          in   1         synchronous, active-high reset
// slot_cs      in   SLOTS     request valid per slot; addr held stable while cs=1
// slot_clr     in   SLOTS     invalidate that slot's cache line
// slot_addr    in   SLOTS*AW  packed slot addresses
// slot_ok      out  SLOTS     data valid for current addr (or write done)
// slot_dout    out  SLOTS*DW  packed slot data
// slot0_wen    in   1         slot 0 access is a write (ignored if WR_EN=0)
// slot0_din    in   16        write data
// slot0_wrmask in   2         write byte mask, 1 = byte NOT written
// sdram_addr   out  22        16-bit word address to controller
// sdram_rd     out  1         read request, held until sdram_ack
// sdram_wr     out  1         write request, held until sdram_ack
// sdram_din    out  16        registered copy of slot0_din
// sdram_wrmask out  2         registered copy of slot0_wrmask
// sdram_ack    in   1         controller accepted request
// data_rdy     in   1         one-cycle strobe: data_read valid / write complete
// data_read    in   32        32-bit burst data, low word = lower address
// BEHAVIOUR
// - Reset: slot_ok=0, slot_dout=0, sdram_rd=0, sdram_wr=0, sdram_addr=0, sdram_din=0,
//   sdram_wrmask=0, all cache lines invalid, RR pointer=0, FSM=IDLE.
// - Line tag = addr>>S, where S=2 (DW=8), 1 (DW=16), 0 (DW=32).
// - SDRAM word address = offset + (DW=8: addr>>1; DW=16: addr; DW=32: addr<<1), forced even (bit0=0).
// - Hit: cs=1, line valid and tag match. slot_ok rises 1 cycle after cs/addr present. dout = selected
//   sub-word: DW=8 byte addr[1:0], DW=16 half addr[0], DW=32 whole line.
// - slot_ok drops the cycle after cs falls, addr changes or clr asserts. It never shows stale data.
// - FSM IDLE->REQ: any cs with a miss, or slot0 write. Arbiter picks one slot. sdram_addr and
//   rd (or wr) are registered the same cycle.
// - REQ->WAIT on sdram_ack: drop rd/wr. WAIT->IDLE on data_rdy: fill the granted slot's line.
//   A read ok follows next cycle via the hit path. A write makes slot_ok[0]=1 one cycle after
//   data_rdy, held until cs drops or addr changes.
// - Round robin: search starts at (last grant+1) mod SLOTS. Fixed priority: lowest index first.
// - Writes: invalidate every slot's line whose SDRAM line address equals the write's. No write
//   allocate. Write is never cached.
// - Addr change during REQ/WAIT: transaction completes and fills the line. ok is only asserted if
//   the tag then matches, otherwise a new request follows.
// - clr during WAIT for the same slot: incoming fill is discarded and the line stays invalid.
// - data_rdy while IDLE/REQ: ignored. ack and data_rdy in the same cycle: treat as ack+rdy, go to IDLE.
// - Reset mid-transaction: rd/wr drop next edge. A late data_rdy after reset is ignored.
// - Throughput: miss costs 1 cycle of arbitration plus controller latency. Hits never stall.
// STRUCTURE
// - Shared include jtcps1_bank.vh: FSM state codes (IDLE,REQ,WAIT), shift/width helper
//   functions (tag shift S, address scale), SDRAM address width 22.
// - Sub-module jtcps1_slot_cache, generated once per slot: tag/valid/data register, hit compare,
//   sub-word mux, ok generation. Top holds the arbiter, FSM and SDRAM regs.
// TESTING
// - SLOTS=2,DW=16: slot0 cs addr 0x10. Expect rd to addr 0x10. data_read=0xBEEF_1234 -> dout 0x1234.
//   Then addr 0x11 -> hit, ok in 1 cycle, 0xBEEF, no new rd.
// - DW=8, OFFSETS slot1=0x10_0000: addr 0x7 -> sdram_addr 0x10_0002. Byte 3 of data_read returned.
// - RR=1, both slots miss continuously: grants alternate 0,1,0,1. RR=0: slot 0 always wins while it misses.
// - WR_EN=1: slot1 caches line 0x20. Slot0 writes 0x20 din=0xAA55 mask=2'b01 -> sdram_wr, mask 01.
//   ok0 after rdy. Slot1 re-reads (miss).
// - slot_clr pulse on a cached slot -> ok low next cycle, next access re-requests.
// - Assert rst during WAIT, then a late data_rdy -> outputs at reset values, cache stays invalid.

Source files
------------

// File: rtl/jtcps1_bank_nslots_pkg.sv
// Shared types and helpers for the N-slot SDRAM bank front-end.
package jtcps1_bank_nslots_pkg;

    localparam int unsigned SDRAM_AW = 22;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } bank_state_e;

    typedef struct packed {
        logic                rd;
        logic                wr;
        logic [SDRAM_AW-1:0] addr;
        logic [15:0]         din;
        logic [1:0]          wrmask;
    } sdram_req_t;

    // Number of slot address bits that select a sub-word inside the 32-bit line.
    function automatic int unsigned tag_shift(input int unsigned dw);
        return (dw == 8) ? 2 : (dw == 16) ? 1 : 0;
    endfunction

    // Slot address (in DW units) to 16-bit SDRAM word address, including the slot offset.
    function automatic logic [SDRAM_AW-1:0] sdram_word(input logic [SDRAM_AW-1:0] offset,
                                                       input logic [31:0] addr,
                                                       input int unsigned dw);
        logic [31:0] scaled;
        scaled = (dw == 8) ? (addr >> 1) : (dw == 16) ? addr : (addr << 1);
        return offset + SDRAM_AW'(scaled);
    endfunction

endpackage

// File: rtl/jtcps1_bank_nslots_cache.sv
// One-line 32-bit cache for a single slot: tag/valid/data, hit compare,
// sub-word selection and ok generation (read hit or completed write).
module jtcps1_bank_nslots_cache
    import jtcps1_bank_nslots_pkg::*;
#(
    parameter int unsigned         AW     = 22,
    parameter int unsigned         DW     = 16,
    parameter logic [SDRAM_AW-1:0] OFFSET = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs_i,
    input  logic                clr_i,
    input  logic                wen_i,
    input  logic [AW-1:0]       addr_i,
    input  logic                fill_i,
    input  logic [AW-1:0]       fill_addr_i,
    input  logic [31:0]         fill_data_i,
    input  logic                wr_done_i,
    input  logic                inval_i,
    input  logic [SDRAM_AW-1:0] inval_line_i,
    output logic                hit_c_o,
    output logic                wdone_c_o,
    output logic                ok_o,
    output logic [DW-1:0]       dout_o
);

    localparam int unsigned S = tag_shift(DW);

    logic                valid_q, valid_d;
    logic [AW-1:0]       tag_q, tag_d;
    logic [31:0]         data_q, data_d;
    logic                wdone_q, wdone_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic                ok_q, ok_d;
    logic [DW-1:0]       dout_q, dout_d;
    logic [SDRAM_AW-1:0] line_word_c;
    logic                line_match_c;
    logic [1:0]          sub_c;

    // Hit detection and the SDRAM line this cache currently holds.
    always_comb begin
        hit_c_o      = cs_i && !wen_i && !clr_i && valid_q && (tag_q == (addr_i >> S));
        wdone_c_o    = wdone_q && cs_i && (addr_i == waddr_q);
        line_word_c  = sdram_word(OFFSET, 32'(tag_q << S), DW);
        line_match_c = ({line_word_c[SDRAM_AW-1:1], 1'b0} == inval_line_i);
        sub_c        = 2'(addr_i) & 2'((1 << S) - 1);
    end

    // Line update (clear beats invalidate beats fill) and registered ok/data.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        waddr_d = waddr_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (inval_i && valid_q && line_match_c) begin
            valid_d = 1'b0;
        end else if (fill_i) begin
            valid_d = 1'b1;
            tag_d   = fill_addr_i >> S;
            data_d  = fill_data_i;
        end
        if (wr_done_i) begin
            waddr_d = addr_i;
        end
        wdone_d = cs_i && !clr_i && (wr_done_i || (wdone_q && (addr_i == waddr_q)));
        ok_d    = hit_c_o || wdone_d;
        dout_d  = hit_c_o ? DW'(data_q >> (DW * sub_c)) : dout_q;
    end

    // Cache state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            wdone_q <= 1'b0;
            waddr_q <= '0;
            ok_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            wdone_q <= wdone_d;
            waddr_q <= waddr_d;
            ok_q    <= ok_d;
            dout_q  <= dout_d;
        end
    end

    assign ok_o   = ok_q;
    assign dout_o = dout_q;

endmodule

// File: rtl/jtcps1_bank_nslots.sv
// N-slot SDRAM bank front-end: per-slot line caches, arbiter and the
// request FSM driving a single SDRAM bank port.
module jtcps1_bank_nslots
    import jtcps1_bank_nslots_pkg::*;
#(
    parameter int unsigned                SLOTS   = 2,
    parameter int unsigned                AW      = 22,
    parameter int unsigned                DW      = 16,
    parameter logic [SLOTS*SDRAM_AW-1:0]  OFFSETS = '0,
    parameter int unsigned                RR      = 1,
    parameter int unsigned                WR_EN   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SLOTS-1:0]      slot_cs_i,
    input  logic [SLOTS-1:0]      slot_clr_i,
    input  logic [SLOTS*AW-1:0]   slot_addr_i,
    output logic [SLOTS-1:0]      slot_ok_o,
    output logic [SLOTS*DW-1:0]   slot_dout_o,
    input  logic                  slot0_wen_i,
    input  logic [15:0]           slot0_din_i,
    input  logic [1:0]            slot0_wrmask_i,
    output logic [21:0]           sdram_addr_o,
    output logic                  sdram_rd_o,
    output logic                  sdram_wr_o,
    output logic [15:0]           sdram_din_o,
    output logic [1:0]            sdram_wrmask_o,
    input  logic                  sdram_ack_i,
    input  logic                  data_rdy_i,
    input  logic [31:0]           data_read_i
);

    localparam int unsigned GW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    bank_state_e         state_q, state_d;
    sdram_req_t          req_q, req_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       last_q, last_d;
    logic                is_wr_q, is_wr_d;
    logic                discard_q, discard_d;
    logic [AW-1:0]       req_addr_q, req_addr_d;

    logic [SLOTS-1:0]    hit_c, wdone_c, wen_c, want_c, fill_c;
    logic [31:0]         start_c;
    logic                pick_vld_c;
    logic [GW-1:0]       pick_c;
    logic                pick_wr_c;
    logic [AW-1:0]       pick_addr_c;
    logic [SDRAM_AW-1:0] pick_word_c;
    logic                clr_gnt_c;
    logic                done_c;
    logic                wr_done_c;

    // Per-slot request: writes until acknowledged as done, reads on a miss.
    always_comb begin
        wen_c    = '0;
        wen_c[0] = (WR_EN != 0) && slot0_wen_i;
        want_c   = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            want_c[i] = slot_cs_i[i] && (wen_c[i] ? !wdone_c[i] : !hit_c[i]);
        end
    end

    // Arbiter: search from last grant + 1 (round robin) or from slot 0.
    always_comb begin
        start_c    = (RR != 0) ? ((32'(last_q) + 32'd1) % SLOTS) : 32'd0;
        pick_vld_c = 1'b0;
        pick_c     = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!pick_vld_c && want_c[i] && (i >= start_c)) begin
                pick_vld_c = 1'b1;
                pick_c     = GW'(i);
            end
        end
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!pick_vld_c && want_c[i] && (i < start_c)) begin
                pick_vld_c = 1'b1;
                pick_c     = GW'(i);
            end
        end
    end

    // Address/offset of the picked slot and clear seen on the granted slot.
    always_comb begin
        pick_addr_c = '0;
        pick_word_c = '0;
        clr_gnt_c   = 1'b0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (pick_c == GW'(i)) begin
                pick_addr_c = slot_addr_i[i*AW +: AW];
                pick_word_c = sdram_word(OFFSETS[i*SDRAM_AW +: SDRAM_AW],
                                         32'(slot_addr_i[i*AW +: AW]), DW);
            end
            if (grant_q == GW'(i)) begin
                clr_gnt_c = slot_clr_i[i];
            end
        end
        pick_wr_c = wen_c[0] && (pick_c == '0);
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_vld_c) state_d = ST_REQ;
            ST_REQ:  if (sdram_ack_i) state_d = data_rdy_i ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (data_rdy_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: request registers, grant bookkeeping and completion events.
    always_comb begin
        req_d      = req_q;
        grant_d    = grant_q;
        last_d     = last_q;
        is_wr_d    = is_wr_q;
        discard_d  = discard_q;
        req_addr_d = req_addr_q;
        done_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld_c) begin
                    grant_d    = pick_c;
                    last_d     = pick_c;
                    is_wr_d    = pick_wr_c;
                    discard_d  = 1'b0;
                    req_addr_d = pick_addr_c;
                    req_d.rd   = !pick_wr_c;
                    req_d.wr   = pick_wr_c;
                    req_d.addr = pick_wr_c ? pick_word_c : {pick_word_c[SDRAM_AW-1:1], 1'b0};
                    if (pick_wr_c) begin
                        req_d.din    = slot0_din_i;
                        req_d.wrmask = slot0_wrmask_i;
                    end
                end
            end
            ST_REQ: begin
                if (sdram_ack_i) begin
                    req_d.rd = 1'b0;
                    req_d.wr = 1'b0;
                    done_c   = data_rdy_i;
                end
                if (clr_gnt_c) discard_d = 1'b1;
            end
            ST_WAIT: begin
                done_c = data_rdy_i;
                if (clr_gnt_c) discard_d = 1'b1;
            end
            default: ;
        endcase
        fill_c = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            fill_c[i] = done_c && !is_wr_q && !discard_q && (grant_q == GW'(i));
        end
        wr_done_c = done_c && is_wr_q;
    end

    // State and SDRAM request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            grant_q    <= '0;
            last_q     <= '0;
            is_wr_q    <= 1'b0;
            discard_q  <= 1'b0;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            is_wr_q    <= is_wr_d;
            discard_q  <= discard_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign sdram_addr_o   = req_q.addr;
    assign sdram_rd_o     = req_q.rd;
    assign sdram_wr_o     = req_q.wr;
    assign sdram_din_o    = req_q.din;
    assign sdram_wrmask_o = req_q.wrmask;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        jtcps1_bank_nslots_cache #(
            .AW     (AW),
            .DW     (DW),
            .OFFSET (OFFSETS[i*SDRAM_AW +: SDRAM_AW])
        ) u_cache (
            .clk          (clk),
            .rst          (rst),
            .cs_i         (slot_cs_i[i]),
            .clr_i        (slot_clr_i[i]),
            .wen_i        (wen_c[i]),
            .addr_i       (slot_addr_i[i*AW +: AW]),
            .fill_i       (fill_c[i]),
            .fill_addr_i  (req_addr_q),
            .fill_data_i  (data_read_i),
            .wr_done_i    (wr_done_c && (i == 0)),
            .inval_i      (wr_done_c),
            .inval_line_i ({req_q.addr[SDRAM_AW-1:1], 1'b0}),
            .hit_c_o      (hit_c[i]),
            .wdone_c_o    (wdone_c[i]),
            .ok_o         (slot_ok_o[i]),
            .dout_o       (slot_dout_o[i*DW +: DW])
        );
    end

endmodule
